alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one combinational ALU (operands a/b, 2-bit b-shift, left/right select, 3-bit ALUControl; produces Result and 4-bit ALUFlag) between two requesters.
- Round-robin arbitration with valid/ready handshakes on both the request and response sides.
- Operands are registered before the ALU, and result and flags are registered after it, so the ALU path is cut at both ends.
- Sits between the requesting sequencers and the ALU instance; the ALU is instantiated outside this block.

Parameters:
- W, 5, operand/result width.
- FW, 4, ALU flag width.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
req_valid  input  2  bit i = requester i has a command
req_ready  output  2  bit i = command from requester i accepted this cycle
req_a  input  2*W  requester i operand a at bits [i*W +: W]
req_b  input  2*W  requester i operand b, same packing
req_bshift  input  4  requester i shift amount at bits [2i+1:2i]
req_lorr  input  2  requester i shift direction
req_ctrl  input  6  requester i ALUControl at bits [3i+2:3i]
alu_a  output  W  registered operand a to ALU
alu_b  output  W  registered operand b to ALU
alu_bshift  output  2  registered shift amount to ALU
alu_lorr  output  1  registered shift direction to ALU
alu_ALUControl  output  3  registered op code to ALU
alu_Result  input  W  ALU result (combinational from the alu_* outputs)
alu_ALUFlag  input  FW  ALU flags
rsp_valid  output  1  response available
rsp_ready  input  1  consumer accepts response
rsp_id  output  1  requester that issued the response
rsp_result  output  W  captured ALU result
rsp_flags  output  FW  captured ALU flags
busy  output  1  state != IDLE

Behaviour:
- Clock, reset and state set:
  - One clock domain: clk, rising edge.
  - reset is synchronous and active-high.
  - FSM states: IDLE, EXEC, HOLD.
- Reset values:
  - state = IDLE; all alu_* outputs = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_result = 0, rsp_flags = 0, busy = 0.
  - Round-robin pointer last_grant = 1, so requester 0 wins the first contest.
- IDLE:
  - req_ready is combinational and is asserted only in IDLE, only for the winner.
  - Winner: the only valid requester, or, if both are valid, the requester != last_grant.
  - On the accept edge: latch the winner's a, b, bshift, lorr and ctrl into the alu_* registers; last_grant <= winner; rsp_id register <= winner; state -> EXEC.
  - If no requester is valid: remain in IDLE; req_ready = 0.
- EXEC (exactly 1 cycle):
  - The ALU settles from the registered operands.
  - On the closing edge: rsp_result <= alu_Result, rsp_flags <= alu_ALUFlag, rsp_valid <= 1; state -> HOLD.
- HOLD:
  - rsp_valid = 1; rsp_id, rsp_result and rsp_flags are held stable.
  - On an edge with rsp_ready = 1: rsp_valid <= 0; state -> IDLE.
- Outside IDLE:
  - req_ready = 00 regardless of req_valid.
  - Requesters must hold their command stable until accepted.
- Latency and throughput:
  - Accept at edge T -> rsp_valid high from cycle T+2.
  - With rsp_ready tied high: rsp_valid is high for exactly one cycle, and the next accept can occur in the cycle after.
  - Maximum throughput: one operation per 3 cycles.
- Pass-through rules:
  - alu_* outputs hold their last command through HOLD and IDLE until the next accept; they are not cleared.
  - ALUControl codes (000 add, 001 sub, 010 and, 011 or, 110, others) pass through unchecked.
  - No arithmetic is performed in this block; widths pass through unchanged.
- Boundary conditions:
  - Starvation is impossible: with both requesters continuously valid, grants strictly alternate.
  - A requester dropping req_valid before grant is legal; no grant is issued to it.
  - rsp_ready asserted while rsp_valid = 0 is ignored.
  - reset in any state (including mid-EXEC or HOLD) discards the in-flight operation; the next cycle shows reset values and the pointer is restored.
  - reset has priority over any simultaneous handshake.

Test Plan:
1. Single request: after reset, req_valid=01, a=3, b=5, bshift=0, lorr=0, ctrl=000, rsp_ready=1.
   - Required: req_ready=01 for one cycle.
   - Required: alu_a=3, alu_b=5 in the EXEC cycle; rsp_valid=1 at T+2 with rsp_id=0 and rsp_result=8.
2. Contention: req_valid=11 held continuously, rsp_ready=1.
   - Required: grant order 0, 1, 0, 1, with accepts spaced 3 cycles apart and rsp_id following the same sequence.
3. Backpressure: req0 a=5, b=5, ctrl=001; rsp_ready=0 for 5 cycles, then 1.
   - Required: rsp_valid, rsp_result=0 and rsp_flags stable for all held cycles; req_ready=00 with req1 valid throughout; busy=1.
   - Required: req1 is granted on the first IDLE cycle after the response handshake.
4. Shift pass-through: only req1 valid, a=2, b=2, bshift=2, lorr=1, ctrl=000.
   - Required: in EXEC, alu_bshift=2, alu_lorr=1, alu_ALUControl=000.
   - Required: rsp_result and rsp_flags equal the alu_Result and alu_ALUFlag values sampled in EXEC; rsp_id=1.
5. Mid-operation reset: assert reset during EXEC of a req1 command.
   - Required: next cycle rsp_valid=0, busy=0, alu_*=0.
   - Required: with req_valid=11 afterwards, requester 0 is granted first.
6. Withdrawn request: req0 valid one cycle during HOLD, deasserted before IDLE.
   - Required: no grant is issued to req0; the FSM stays in IDLE.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one external combinational ALU between two requesters.
// Operands are registered on the way into the ALU and result/flags on the way out.
module alu_arbiter #(
    parameter int W  = 5,
    parameter int FW = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [2*W-1:0]  req_a,
    input  logic [2*W-1:0]  req_b,
    input  logic [3:0]      req_bshift,
    input  logic [1:0]      req_lorr,
    input  logic [5:0]      req_ctrl,
    output logic [W-1:0]    alu_a,
    output logic [W-1:0]    alu_b,
    output logic [1:0]      alu_bshift,
    output logic            alu_lorr,
    output logic [2:0]      alu_ALUControl,
    input  logic [W-1:0]    alu_Result,
    input  logic [FW-1:0]   alu_ALUFlag,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [W-1:0]    rsp_result,
    output logic [FW-1:0]   rsp_flags,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    state_t          state_q;
    logic            last_q;
    logic [W-1:0]    alu_a_q;
    logic [W-1:0]    alu_b_q;
    logic [1:0]      alu_bshift_q;
    logic            alu_lorr_q;
    logic [2:0]      alu_ctrl_q;
    logic            rsp_valid_q;
    logic            rsp_id_q;
    logic [W-1:0]    rsp_result_q;
    logic [FW-1:0]   rsp_flags_q;

    logic            any_vld;
    logic            win_d;
    logic [W-1:0]    sel_a_d;
    logic [W-1:0]    sel_b_d;
    logic [1:0]      sel_bshift_d;
    logic            sel_lorr_d;
    logic [2:0]      sel_ctrl_d;

    // With both valid, the requester that did not win last time goes first.
    always_comb begin
        any_vld      = |req_valid;
        win_d        = req_valid[1] & (~req_valid[0] | ~last_q);
        req_ready    = 2'b00;
        if (state_q == IDLE && any_vld) begin
            req_ready = win_d ? 2'b10 : 2'b01;
        end
        sel_a_d      = win_d ? req_a[2*W-1:W] : req_a[W-1:0];
        sel_b_d      = win_d ? req_b[2*W-1:W] : req_b[W-1:0];
        sel_bshift_d = win_d ? req_bshift[3:2] : req_bshift[1:0];
        sel_lorr_d   = win_d ? req_lorr[1]     : req_lorr[0];
        sel_ctrl_d   = win_d ? req_ctrl[5:3]   : req_ctrl[2:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_q       <= 1'b1;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_bshift_q <= '0;
            alu_lorr_q   <= 1'b0;
            alu_ctrl_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Operand stage: alu_* keep the previous command until the next accept.
                    if (any_vld) begin
                        alu_a_q      <= sel_a_d;
                        alu_b_q      <= sel_b_d;
                        alu_bshift_q <= sel_bshift_d;
                        alu_lorr_q   <= sel_lorr_d;
                        alu_ctrl_q   <= sel_ctrl_d;
                        last_q       <= win_d;
                        rsp_id_q     <= win_d;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    // Result stage: capture what the ALU settled to during this cycle.
                    rsp_result_q <= alu_Result;
                    rsp_flags_q  <= alu_ALUFlag;
                    rsp_valid_q  <= 1'b1;
                    state_q      <= HOLD;
                end
                HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alu_a          = alu_a_q;
    assign alu_b          = alu_b_q;
    assign alu_bshift     = alu_bshift_q;
    assign alu_lorr       = alu_lorr_q;
    assign alu_ALUControl = alu_ctrl_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_id         = rsp_id_q;
    assign rsp_result     = rsp_result_q;
    assign rsp_flags      = rsp_flags_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU on the alu_* side, vector table plus
// hand-written multi-cycle sequences, and a response scoreboard.
module tb_alu_arbiter;
    localparam int W  = 5;
    localparam int FW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic [1:0]     req_valid, req_ready;
    logic [2*W-1:0] req_a, req_b;
    logic [3:0]     req_bshift;
    logic [1:0]     req_lorr;
    logic [5:0]     req_ctrl;
    logic [W-1:0]   alu_a, alu_b;
    logic [1:0]     alu_bshift;
    logic           alu_lorr;
    logic [2:0]     alu_ALUControl;
    logic [W-1:0]   alu_Result;
    logic [FW-1:0]  alu_ALUFlag;
    logic           rsp_valid, rsp_ready, rsp_id;
    logic [W-1:0]   rsp_result;
    logic [FW-1:0]  rsp_flags;
    logic           busy;

    alu_arbiter #(.W(W), .FW(FW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_bshift(req_bshift),
        .req_lorr(req_lorr), .req_ctrl(req_ctrl),
        .alu_a(alu_a), .alu_b(alu_b), .alu_bshift(alu_bshift),
        .alu_lorr(alu_lorr), .alu_ALUControl(alu_ALUControl),
        .alu_Result(alu_Result), .alu_ALUFlag(alu_ALUFlag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
    );

    // Reference ALU: returns {N,Z,C,V, result}; b is shifted before the operation.
    function automatic logic [FW+W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [1:0] bs, input logic lr,
                                               input logic [2:0] op);
        logic [W-1:0] sb, r;
        logic [W:0]   s;
        logic         c, v;
        sb = lr ? (b >> bs) : (b << bs);
        c = 1'b0; v = 1'b0; r = '0; s = '0;
        case (op)
            3'b000: begin
                s = {1'b0, a} + {1'b0, sb};
                r = s[W-1:0]; c = s[W];
                v = (a[W-1] == sb[W-1]) && (r[W-1] != a[W-1]);
            end
            3'b001: begin
                s = {1'b0, a} + {1'b0, ~sb} + (W+1)'(1);
                r = s[W-1:0]; c = s[W];
                v = (a[W-1] != sb[W-1]) && (r[W-1] != a[W-1]);
            end
            3'b010: r = a & sb;
            3'b011: r = a | sb;
            3'b110: r = a ^ sb;
            default: r = '0;
        endcase
        return {r[W-1], (r == '0), c, v, r};
    endfunction

    assign {alu_ALUFlag, alu_Result} = alu_fn(alu_a, alu_b, alu_bshift, alu_lorr, alu_ALUControl);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    typedef struct {
        logic          id;
        logic [W-1:0]  res;
        logic [FW-1:0] fl;
    } exp_t;

    exp_t sb_q[$];
    logic gl[$];
    int   gcyc[$];
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: push on accept, pop on response handshake.
    always @(negedge clk) begin
        logic [1:0] acc;
        logic       w;
        exp_t       e;
        if (reset) begin
            sb_q.delete();
        end else begin
            acc = req_ready & req_valid;
            if (acc != 2'b00) begin
                w = acc[1];
                e.id = w;
                {e.fl, e.res} = alu_fn(w ? req_a[2*W-1:W] : req_a[W-1:0],
                                       w ? req_b[2*W-1:W] : req_b[W-1:0],
                                       w ? req_bshift[3:2] : req_bshift[1:0],
                                       w ? req_lorr[1] : req_lorr[0],
                                       w ? req_ctrl[5:3] : req_ctrl[2:0]);
                sb_q.push_back(e);
                gl.push_back(w);
                gcyc.push_back(cyc);
            end
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_rsp", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_id", int'(rsp_id), int'(e.id));
                    chk("sb_result", int'(rsp_result), int'(e.res));
                    chk("sb_flags", int'(rsp_flags), int'(e.fl));
                end
            end
        end
    end

    typedef struct {
        logic          id;
        logic [W-1:0]  a, b;
        logic [1:0]    bs;
        logic          lr;
        logic [2:0]    op;
        logic [W-1:0]  res;
        logic [FW-1:0] fl;
    } vec_t;

    vec_t vt[10];

    task automatic set_req(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [1:0] bs, input logic lr, input logic [2:0] op);
        if (id) begin
            req_a[2*W-1:W] = a; req_b[2*W-1:W] = b;
            req_bshift[3:2] = bs; req_lorr[1] = lr; req_ctrl[5:3] = op;
        end else begin
            req_a[W-1:0] = a; req_b[W-1:0] = b;
            req_bshift[1:0] = bs; req_lorr[0] = lr; req_ctrl[2:0] = op;
        end
    endtask

    task automatic cyc_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string nm);
        logic done;
        done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (!busy && !rsp_valid && sb_q.size() == 0) begin
                done = 1'b1;
                break;
            end
            cyc_step();
        end
        chk(nm, int'(done), 1);
    endtask

    initial begin
        logic [W-1:0]  ex_res;
        logic [FW-1:0] ex_fl;
        int n;

        vt[0] = '{1'b0, 5'd3,  5'd5,  2'd0, 1'b0, 3'b000, 5'd8,  4'b0000};
        vt[1] = '{1'b0, 5'd5,  5'd5,  2'd0, 1'b0, 3'b001, 5'd0,  4'b0110};
        vt[2] = '{1'b1, 5'd2,  5'd2,  2'd2, 1'b1, 3'b000, 5'd2,  4'b0000};
        vt[3] = '{1'b1, 5'd12, 5'd3,  2'd1, 1'b0, 3'b010, 5'd4,  4'b0000};
        vt[4] = '{1'b0, 5'd16, 5'd1,  2'd0, 1'b0, 3'b011, 5'd17, 4'b1000};
        vt[5] = '{1'b1, 5'd15, 5'd1,  2'd0, 1'b0, 3'b000, 5'd16, 4'b1001};
        vt[6] = '{1'b0, 5'd31, 5'd1,  2'd0, 1'b0, 3'b000, 5'd0,  4'b0110};
        vt[7] = '{1'b1, 5'd10, 5'd10, 2'd0, 1'b0, 3'b110, 5'd0,  4'b0100};
        vt[8] = '{1'b0, 5'd7,  5'd9,  2'd0, 1'b0, 3'b111, 5'd0,  4'b0100};
        vt[9] = '{1'b1, 5'd3,  5'd24, 2'd3, 1'b1, 3'b011, 5'd3,  4'b0000};

        reset = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
        req_a = '0; req_b = '0; req_bshift = '0; req_lorr = '0; req_ctrl = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rsp_id", int'(rsp_id), 0);
        chk("rst_rsp_result", int'(rsp_result), 0);
        chk("rst_rsp_flags", int'(rsp_flags), 0);
        chk("rst_alu_a", int'(alu_a), 0);
        chk("rst_alu_b", int'(alu_b), 0);
        chk("rst_alu_bshift", int'(alu_bshift), 0);
        chk("rst_alu_lorr", int'(alu_lorr), 0);
        chk("rst_alu_ctrl", int'(alu_ALUControl), 0);
        reset = 1'b0;
        #1;
        chk("idle_no_req_ready", int'(req_ready), 0);
        cyc_step();

        // Table: single requests with rsp_ready high.
        for (int i = 0; i < 10; i++) begin
            rsp_ready = 1'b1;
            set_req(vt[i].id, vt[i].a, vt[i].b, vt[i].bs, vt[i].lr, vt[i].op);
            req_valid = vt[i].id ? 2'b10 : 2'b01;
            #1;
            chk("vec_req_ready", int'(req_ready), vt[i].id ? 2 : 1);
            cyc_step();
            req_valid = 2'b00;
            chk("vec_exec_busy", int'(busy), 1);
            chk("vec_exec_ready", int'(req_ready), 0);
            chk("vec_alu_a", int'(alu_a), int'(vt[i].a));
            chk("vec_alu_b", int'(alu_b), int'(vt[i].b));
            chk("vec_alu_bshift", int'(alu_bshift), int'(vt[i].bs));
            chk("vec_alu_lorr", int'(alu_lorr), int'(vt[i].lr));
            chk("vec_alu_ctrl", int'(alu_ALUControl), int'(vt[i].op));
            chk("vec_exec_rsp_valid", int'(rsp_valid), 0);
            ex_res = alu_Result;
            ex_fl  = alu_ALUFlag;
            cyc_step();
            chk("vec_rsp_valid", int'(rsp_valid), 1);
            chk("vec_rsp_id", int'(rsp_id), int'(vt[i].id));
            chk("vec_rsp_result", int'(rsp_result), int'(vt[i].res));
            chk("vec_rsp_flags", int'(rsp_flags), int'(vt[i].fl));
            chk("vec_rsp_vs_exec_res", int'(rsp_result), int'(ex_res));
            chk("vec_rsp_vs_exec_fl", int'(rsp_flags), int'(ex_fl));
            cyc_step();
            chk("vec_back_idle_valid", int'(rsp_valid), 0);
            chk("vec_back_idle_busy", int'(busy), 0);
        end

        // Contention: both valid continuously, grants must alternate 0,1,0,1.
        gl.delete(); gcyc.delete();
        set_req(1'b0, 5'd4, 5'd1, 2'd0, 1'b0, 3'b000);
        set_req(1'b1, 5'd9, 5'd3, 2'd0, 1'b0, 3'b001);
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        for (int k = 0; k < 40; k++) begin
            if (gl.size() >= 4) break;
            cyc_step();
        end
        req_valid = 2'b00;
        wait_idle("cont_drain");
        chk("cont_grant_count", gl.size(), 4);
        if (gl.size() >= 4) begin
            for (int k = 0; k < 4; k++) chk("cont_grant_order", int'(gl[k]), k % 2);
            for (int k = 0; k < 3; k++) chk("cont_spacing", gcyc[k+1] - gcyc[k], 3);
        end

        // Backpressure: req0 sub held in HOLD while req1 waits.
        gl.delete();
        set_req(1'b0, 5'd5, 5'd5, 2'd0, 1'b0, 3'b001);
        set_req(1'b1, 5'd1, 5'd2, 2'd0, 1'b0, 3'b000);
        rsp_ready = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("bp_req_ready", int'(req_ready), 1);
        cyc_step();
        req_valid = 2'b10;
        #1;
        chk("bp_exec_ready", int'(req_ready), 0);
        cyc_step();
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold_valid", int'(rsp_valid), 1);
            chk("bp_hold_result", int'(rsp_result), 0);
            chk("bp_hold_flags", int'(rsp_flags), 4'b0110);
            chk("bp_hold_ready", int'(req_ready), 0);
            chk("bp_hold_busy", int'(busy), 1);
            cyc_step();
        end
        rsp_ready = 1'b1;
        cyc_step();
        #1;
        chk("bp_req1_granted", int'(req_ready), 2);
        cyc_step();
        req_valid = 2'b00;
        wait_idle("bp_drain");
        chk("bp_grant_count", gl.size(), 2);

        // Reset during EXEC of a req1 command.
        set_req(1'b1, 5'd6, 5'd7, 2'd1, 1'b1, 3'b011);
        req_valid = 2'b10;
        cyc_step();
        req_valid = 2'b00;
        reset = 1'b1;
        cyc_step();
        chk("rx_rsp_valid", int'(rsp_valid), 0);
        chk("rx_busy", int'(busy), 0);
        chk("rx_alu_a", int'(alu_a), 0);
        chk("rx_alu_b", int'(alu_b), 0);
        chk("rx_alu_bshift", int'(alu_bshift), 0);
        chk("rx_alu_lorr", int'(alu_lorr), 0);
        chk("rx_alu_ctrl", int'(alu_ALUControl), 0);
        reset = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("rx_first_grant", int'(req_ready), 1);
        cyc_step();
        req_valid = 2'b00;
        wait_idle("rx_drain");

        // Reset during HOLD of a req0 command must restore the pointer to 1.
        set_req(1'b0, 5'd2, 5'd3, 2'd0, 1'b0, 3'b000);
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        cyc_step();
        req_valid = 2'b00;
        cyc_step();
        chk("rh_in_hold", int'(rsp_valid), 1);
        reset = 1'b1;
        cyc_step();
        chk("rh_rsp_valid", int'(rsp_valid), 0);
        reset = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("rh_ptr_restored", int'(req_ready), 1);
        cyc_step();
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        wait_idle("rh_drain");

        // Withdrawn request: req0 valid for one HOLD cycle only.
        set_req(1'b1, 5'd8, 5'd4, 2'd0, 1'b0, 3'b010);
        rsp_ready = 1'b0;
        req_valid = 2'b10;
        cyc_step();
        req_valid = 2'b00;
        cyc_step();
        set_req(1'b0, 5'd1, 5'd1, 2'd0, 1'b0, 3'b000);
        req_valid = 2'b01;
        #1;
        chk("wd_hold_ready", int'(req_ready), 0);
        n = gl.size();
        cyc_step();
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        cyc_step();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("wd_no_grant", int'(req_ready), 0);
            chk("wd_stays_idle", int'(busy), 0);
            cyc_step();
        end
        chk("wd_grant_log", gl.size(), n);

        wait_idle("final_drain");
        chk("final_sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout actual=%0d required=0", 1);
        $fatal(1);
    end
endmodule
